// File: rtl/set_control.sv
// Clock set-mode controller: synchronizes and debounces three buttons, walks the
// field-select state machine and produces single-cycle up/down adjust strobes with auto-repeat.

module set_control_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [5:0] mode,
    input logic       up,
    input logic       down,
    input logic       setting
);

    a_mode_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(mode));
    a_no_up_and_down: assert property (@(posedge clk) disable iff (!rst_n) !(up && down));
    a_setting_is_or: assert property (@(posedge clk) disable iff (!rst_n) setting == (|mode));

endmodule

module set_control #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100,
    parameter int IDLE_TIMEOUT    = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_mode,
    input  logic btn_up,
    input  logic btn_down,
    output logic mode_second,
    output logic mode_minute,
    output logic mode_hour,
    output logic mode_day,
    output logic mode_month,
    output logic mode_year,
    output logic up,
    output logic down,
    output logic setting
);

    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    localparam int DB_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DB_W     = (DB_W_RAW < 1) ? 1 : DB_W_RAW;
    localparam int RP_MAXI  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W_RAW = $clog2(RP_MAXI + 1);
    localparam int RP_W     = (RP_W_RAW < 1) ? 1 : RP_W_RAW;
    localparam int ID_W_RAW = $clog2(IDLE_TIMEOUT + 1);
    localparam int ID_W     = (ID_W_RAW < 1) ? 1 : ID_W_RAW;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);
    localparam logic [RP_W-1:0] RP_MAX  = RP_W'(RP_MAXI);
    localparam logic [ID_W-1:0] ID_MAX  = ID_W'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } state_t;

    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      deb_r;
    logic [2:0]      deb_prev_r;
    logic [DB_W-1:0] db_cnt_r [0:2];
    logic [2:0]      rise_s;

    state_t          state_r;
    state_t          state_next_s;
    logic [5:0]      mode_r;
    logic            up_r;
    logic            down_r;
    logic            up_next_s;
    logic            down_next_s;
    logic [RP_W-1:0] rep_cnt_r;
    logic [RP_W-1:0] rep_cnt_next_s;
    logic            rep_phase_r;
    logic            rep_phase_next_s;
    logic [ID_W-1:0] idle_cnt_r;

    function automatic logic [5:0] mode_decode(input state_t s);
        logic [5:0] m;
        case (s)
            ST_SEC:   m = 6'b000001;
            ST_MIN:   m = 6'b000010;
            ST_HOUR:  m = 6'b000100;
            ST_DAY:   m = 6'b001000;
            ST_MONTH: m = 6'b010000;
            ST_YEAR:  m = 6'b100000;
            default:  m = 6'b000000;
        endcase
        return m;
    endfunction

    // Two-flop synchronizer for the raw buttons {down, up, mode}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= {btn_down, btn_up, btn_mode};
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a level flips only after a full run of differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r      <= 3'b000;
            deb_prev_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            deb_prev_r <= deb_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] >= DB_LAST) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= {DB_W{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end
            end
        end
    end

    assign rise_s = deb_r & ~deb_prev_r;

    // Next state: mode edges walk the ring, an expired idle count drops back to RUN.
    always_comb begin
        state_next_s = state_r;
        if (rise_s[BTN_MODE]) begin
            case (state_r)
                ST_RUN:   state_next_s = ST_SEC;
                ST_SEC:   state_next_s = ST_MIN;
                ST_MIN:   state_next_s = ST_HOUR;
                ST_HOUR:  state_next_s = ST_DAY;
                ST_DAY:   state_next_s = ST_MONTH;
                ST_MONTH: state_next_s = ST_YEAR;
                ST_YEAR:  state_next_s = ST_RUN;
                default:  state_next_s = ST_RUN;
            endcase
        end else if ((state_r != ST_RUN) && (idle_cnt_r == ID_MAX)) begin
            state_next_s = ST_RUN;
        end else begin
            state_next_s = state_r;
        end
    end

    // Strobe and repeat timing; phase 0 waits REPEAT_DELAY, phase 1 paces at REPEAT_RATE.
    always_comb begin
        up_next_s        = 1'b0;
        down_next_s      = 1'b0;
        rep_cnt_next_s   = rep_cnt_r;
        rep_phase_next_s = rep_phase_r;
        if ((state_r == ST_RUN) || rise_s[BTN_MODE] || (deb_r[BTN_UP] == deb_r[BTN_DOWN])) begin
            // Nothing held, both held, in RUN or advancing: stay silent and rearm.
            rep_cnt_next_s   = {RP_W{1'b0}};
            rep_phase_next_s = 1'b0;
        end else if (rise_s[BTN_UP] || rise_s[BTN_DOWN]) begin
            up_next_s        = rise_s[BTN_UP];
            down_next_s      = rise_s[BTN_DOWN];
            rep_cnt_next_s   = {RP_W{1'b0}};
            rep_phase_next_s = 1'b0;
        end else if ((!rep_phase_r && (rep_cnt_r >= RD_LAST)) ||
                     (rep_phase_r && (rep_cnt_r >= RR_LAST))) begin
            up_next_s        = deb_r[BTN_UP];
            down_next_s      = deb_r[BTN_DOWN];
            rep_cnt_next_s   = {RP_W{1'b0}};
            rep_phase_next_s = 1'b1;
        end else if (rep_cnt_r != RP_MAX) begin
            rep_cnt_next_s = rep_cnt_r + {{(RP_W-1){1'b0}}, 1'b1};
        end else begin
            rep_cnt_next_s = rep_cnt_r;
        end
    end

    // State, registered outputs, repeat and idle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            mode_r      <= 6'b000000;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            rep_cnt_r   <= {RP_W{1'b0}};
            rep_phase_r <= 1'b0;
            idle_cnt_r  <= {ID_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            mode_r      <= mode_decode(state_next_s);
            up_r        <= up_next_s;
            down_r      <= down_next_s;
            rep_cnt_r   <= rep_cnt_next_s;
            rep_phase_r <= rep_phase_next_s;
            if ((state_r == ST_RUN) || (rise_s != 3'b000) || (deb_r != 3'b000)) begin
                idle_cnt_r <= {ID_W{1'b0}};
            end else if (idle_cnt_r != ID_MAX) begin
                idle_cnt_r <= idle_cnt_r + {{(ID_W-1){1'b0}}, 1'b1};
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
        end
    end

    assign mode_second = mode_r[0];
    assign mode_minute = mode_r[1];
    assign mode_hour   = mode_r[2];
    assign mode_day    = mode_r[3];
    assign mode_month  = mode_r[4];
    assign mode_year   = mode_r[5];
    assign up          = up_r;
    assign down        = down_r;
    assign setting     = |mode_r;

    set_control_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_r),
        .up      (up_r),
        .down    (down_r),
        .setting (setting)
    );

endmodule

// File: tb/tb_set_control.sv
// Self-checking bench for set_control: expected strobe cycles are queued as buttons
// are driven and matched against the DUT outputs on every falling clock edge.

module tb_set_control;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int IT = 50;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_mode, btn_up, btn_down;
    logic mode_second, mode_minute, mode_hour, mode_day, mode_month, mode_year;
    logic up, down, setting;
    logic [5:0] mv;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_up[$];
    int unsigned exp_dn[$];
    int unsigned up_seen = 0;
    int unsigned dn_seen = 0;
    int unsigned c, r, u, rel, up0, dn0;

    set_control #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .IDLE_TIMEOUT    (IT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .mode_second (mode_second),
        .mode_minute (mode_minute),
        .mode_hour   (mode_hour),
        .mode_day    (mode_day),
        .mode_month  (mode_month),
        .mode_year   (mode_year),
        .up          (up),
        .down        (down),
        .setting     (setting)
    );

    assign mv = {mode_year, mode_month, mode_day, mode_hour, mode_minute, mode_second};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned got, input int unsigned expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Scoreboard: an expected strobe cycle must see the strobe; any other strobe is an error.
    always @(negedge clk) begin
        if (up === 1'b1) up_seen++;
        if (down === 1'b1) dn_seen++;
        if (exp_up.size() > 0 && exp_up[0] == cyc) begin
            check("up_pulse", up, 1);
            void'(exp_up.pop_front());
        end else if (up !== 1'b0) begin
            check("up_extra", up, 0);
        end
        if (exp_dn.size() > 0 && exp_dn[0] == cyc) begin
            check("down_pulse", down, 1);
            void'(exp_dn.pop_front());
        end else if (down !== 1'b0) begin
            check("down_extra", down, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_mode = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(3);
        check("rst_mode", mv, 0);
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_setting", setting, 0);
        rst_n = 1'b1;
        tick(2);

        // Seven clean mode presses walk the whole ring; first one checks latency.
        c = cyc;
        btn_mode = 1'b1;
        tick(6);
        check("mode_lat_pre", mv, 0);
        tick(1);
        check("mode_lat", mv, 1);
        check("setting_lat", setting, 1);
        tick(1);
        btn_mode = 1'b0;
        tick(8);
        for (int k = 2; k <= 7; k++) begin
            press_mode();
            check("mode_seq", mv, (k <= 6) ? (32'd1 << (k - 1)) : 32'd0);
            check("setting_seq", setting, (k <= 6) ? 1 : 0);
        end

        // Bouncing mode button never debounces.
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 0);
            tick(2);
        end
        btn_mode = 1'b0;
        tick(20);
        check("bounce_mode", mv, 0);
        check("bounce_setting", setting, 0);

        // Auto-repeat in SET_MIN.
        do_reset();
        press_mode();
        press_mode();
        check("min_mode", mv, 2);
        up0 = up_seen;
        dn0 = dn_seen;
        c = cyc;
        btn_up = 1'b1;
        exp_up.push_back(c + 7);
        for (int unsigned t = c + 17; t <= c + 46; t += 3) exp_up.push_back(t);
        tick(40);
        btn_up = 1'b0;
        tick(20);
        check("rpt_queue", exp_up.size(), 0);
        check("rpt_count", up_seen - up0, 11);
        check("rpt_down", dn_seen - dn0, 0);
        check("rpt_mode", mv, 2);

        // Both buttons held in SET_DAY, then down released.
        do_reset();
        for (int k = 0; k < 4; k++) press_mode();
        check("day_mode", mv, 8);
        up0 = up_seen;
        dn0 = dn_seen;
        c = cyc;
        btn_up = 1'b1;
        exp_up.push_back(c + 7);
        exp_up.push_back(c + 17);
        exp_up.push_back(c + 20);
        exp_up.push_back(c + 23);
        exp_up.push_back(c + 26);
        tick(20);
        btn_down = 1'b1;
        tick(20);
        r = cyc;
        btn_down = 1'b0;
        for (int unsigned t = r + 16; t <= r + 26; t += 3) exp_up.push_back(t);
        tick(20);
        btn_up = 1'b0;
        tick(20);
        check("both_queue", exp_up.size(), 0);
        check("both_count", up_seen - up0, 9);
        check("both_down", dn_seen - dn0, 0);
        check("both_mode", mv, 8);

        // Idle timeout from SET_YEAR, then up presses in RUN are ignored.
        do_reset();
        for (int k = 0; k < 5; k++) press_mode();
        btn_mode = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        rel = cyc;
        check("year_mode", mv, 32);
        tick(50);
        check("idle_hold", mv, 32);
        tick(10);
        check("idle_run", mv, 0);
        check("idle_setting", setting, 0);
        up0 = up_seen;
        btn_up = 1'b1;
        tick(30);
        btn_up = 1'b0;
        tick(15);
        check("run_no_up", up_seen - up0, 0);
        check("run_mode", mv, 0);

        // Reset in SET_HOUR with up held.
        do_reset();
        for (int k = 0; k < 3; k++) press_mode();
        check("hour_mode", mv, 4);
        c = cyc;
        btn_up = 1'b1;
        exp_up.push_back(c + 7);
        tick(12);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_mode", mv, 0);
        check("mid_rst_up", up, 0);
        check("mid_rst_down", down, 0);
        check("mid_rst_setting", setting, 0);
        tick(2);
        rst_n = 1'b1;
        up0 = up_seen;
        tick(20);
        btn_up = 1'b0;
        tick(20);
        check("post_rst_up", up_seen - up0, 0);
        check("post_rst_mode", mv, 0);
        check("post_rst_queue", exp_up.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
